// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and SPI mode constants for spi_primary.
// No ports. spi_primary imports the state type and uses CPOL as the idle level of sclk.
// CPHA documents the fixed sampling phase; this controller only implements CPHA=0.
package spi_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_state_t;
    localparam bit CPOL = 1'b0;
    localparam bit CPHA = 1'b0;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period tick generator for the SPI serial clock.
// Ports: clk, rst_n (async, active low) -- clock and reset.
//        en   -- advances the divider while high.
//        clr  -- synchronously returns the divider to zero.
//        tick -- one-cycle pulse at the end of every CLK_DIV enabled cycles.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV + 1);
    logic [CW-1:0] cnt;
    assign tick = en && (cnt == CW'(CLK_DIV - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/spi_primary.sv
// spi_primary: mode-0 SPI controller issuing single-word transfers to one of NUM_CS secondaries.
// Ports: clk, rst_n (async, active low) -- clock and reset.
//        start, tx_data, cs_sel        -- transfer request, captured when accepted in IDLE.
//        busy, done, rx_data           -- frame in progress, one-cycle completion pulse, received word.
//        sclk, mosi, miso, cs_n        -- serial bus (sclk idles low, cs_n active low).
module spi_primary
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2,
    parameter int NUM_CS  = 2,
    parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);
    localparam int BW = $clog2(DATA_W + 1);

    spi_state_t        state, state_d;
    logic              sclk_d, mosi_d, busy_d, done_d, tick;
    logic [NUM_CS-1:0] cs_n_d;
    logic [DATA_W-1:0] rx_d, sh, sh_d;
    logic [BW-1:0]     bit_cnt, bit_d;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state != IDLE),
        .clr   (state == IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sclk    <= CPOL;
            mosi    <= 1'b0;
            cs_n    <= '1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            sh      <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_d;
            sclk    <= sclk_d;
            mosi    <= mosi_d;
            cs_n    <= cs_n_d;
            busy    <= busy_d;
            done    <= done_d;
            rx_data <= rx_d;
            sh      <= sh_d;
            bit_cnt <= bit_d;
        end
    end

    // sh holds the outgoing word; each rise shifts it left, pushing miso into the LSB,
    // so its MSB is always the next bit to present on mosi at the following fall.
    always_comb begin
        state_d = state;
        sclk_d  = sclk;
        mosi_d  = mosi;
        cs_n_d  = cs_n;
        busy_d  = busy;
        done_d  = 1'b0;
        rx_d    = rx_data;
        sh_d    = sh;
        bit_d   = bit_cnt;
        case (state)
            IDLE: if (start && int'(cs_sel) < NUM_CS) begin
                state_d = SETUP;
                cs_n_d  = ~(NUM_CS'(1) << cs_sel);
                busy_d  = 1'b1;
                sh_d    = tx_data;
                mosi_d  = tx_data[DATA_W-1];
                bit_d   = '0;
            end
            SETUP, SHIFT: if (tick) begin
                state_d = SHIFT;
                // After the last fall, sclk stays low for one more half-period before HOLD.
                if (!sclk && bit_cnt == BW'(DATA_W)) state_d = HOLD;
                else begin
                    sclk_d = !sclk;
                    if (!sclk) begin
                        sh_d  = {sh[DATA_W-2:0], miso};
                        bit_d = bit_cnt + 1'b1;
                    end else if (bit_cnt != BW'(DATA_W)) mosi_d = sh[DATA_W-1];
                end
            end
            HOLD: if (tick) begin
                state_d = IDLE;
                cs_n_d  = '1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                rx_d    = sh;
                mosi_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_primary.sv
// tb_spi_primary: directed self-checking bench for spi_primary (8-bit/div-2 and 16-bit/div-1 instances).
module tb_spi_primary;
    logic clk = 1'b0, rst_n = 1'b0;
    logic sel = 1'b0, start_v = 1'b0, clr = 1'b0;
    logic [15:0] tx_v = '0, pat = '0;
    logic [1:0] cs_v = '0;
    int dw;
    logic miso_v;

    logic        start_a, busy_a, done_a, sclk_a, mosi_a, miso_a;
    logic [7:0]  tx_a, rx_a;
    logic [1:0]  cs_sel_a, cs_n_a;
    logic        start_b, busy_b, done_b, sclk_b, mosi_b, miso_b;
    logic [15:0] tx_b, rx_b;
    logic [0:0]  cs_sel_b;
    logic [1:0]  cs_n_b;

    logic        sclk_m, mosi_m, busy_m, done_m;
    logic [1:0]  cs_n_m;
    logic [15:0] rx_m;

    int n_tests = 0, n_fail = 0;
    int n_busy = 0, n_rise = 0, n_fall = 0, n_done = 0, n_bad = 0;
    int cyc = 0, last_rise = 0, rise_per = 0;
    logic [1:0]  cs_seen = '0;
    logic [15:0] got_mosi = '0, rx_at_done = '0;
    logic        sclk_p = 1'b0;

    always #5 clk = ~clk;

    spi_primary #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(2), .CS_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_a), .cs_sel(cs_sel_a),
        .busy(busy_a), .done(done_a), .rx_data(rx_a), .sclk(sclk_a), .mosi(mosi_a),
        .miso(miso_a), .cs_n(cs_n_a)
    );

    spi_primary #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_b), .cs_sel(cs_sel_b),
        .busy(busy_b), .done(done_b), .rx_data(rx_b), .sclk(sclk_b), .mosi(mosi_b),
        .miso(miso_b), .cs_n(cs_n_b)
    );

    assign start_a  = start_v & ~sel;
    assign start_b  = start_v & sel;
    assign tx_a     = tx_v[7:0];
    assign tx_b     = tx_v;
    assign cs_sel_a = cs_v;
    assign cs_sel_b = cs_v[0];
    assign sclk_m   = sel ? sclk_b : sclk_a;
    assign mosi_m   = sel ? mosi_b : mosi_a;
    assign busy_m   = sel ? busy_b : busy_a;
    assign done_m   = sel ? done_b : done_a;
    assign cs_n_m   = sel ? cs_n_b : cs_n_a;
    assign rx_m     = sel ? rx_b : {8'h00, rx_a};

    // Secondary model: presents pattern MSB first, advancing after each sclk fall.
    assign dw     = sel ? 16 : 8;
    assign miso_v = (n_fall < dw) ? pat[4'(dw - 1 - n_fall)] : 1'b0;
    assign miso_a = miso_v;
    assign miso_b = miso_v;

    // Bus monitor, sampled 1ns after each rising edge; clr restarts the per-frame statistics.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (clr) begin
            n_busy = 0; n_rise = 0; n_fall = 0; n_done = 0;
            cs_seen = '0; got_mosi = '0;
        end
        if (busy_m) n_busy++;
        if (done_m) begin n_done++; rx_at_done = rx_m; end
        cs_seen = cs_seen | ~cs_n_m;
        if (sclk_m != sclk_p && cs_n_m == 2'b11 && rst_n) n_bad++;
        if (sclk_m && !sclk_p) begin
            got_mosi = {got_mosi[14:0], mosi_m};
            n_rise++;
            rise_per = cyc - last_rise;
            last_rise = cyc;
        end
        if (!sclk_m && sclk_p) n_fall++;
        sclk_p = sclk_m;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [15:0] tx, input logic [1:0] cs, input logic [15:0] p);
        tx_v = tx; cs_v = cs; pat = p; start_v = 1'b1; clr = 1'b1;
        @(negedge clk);
        start_v = 1'b0; clr = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) @(negedge clk);
        chk("done_seen", n_done, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(cs_n_a), 32'h3);
        chk("rst_sclk", 32'(sclk_a), 0);
        chk("rst_mosi", 32'(mosi_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_rx", 32'(rx_a), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        xfer(16'h00A5, 2'd0, 16'h003C);
        chk("t1_cs_first", 32'(cs_n_m), 32'h2);
        chk("t1_busy_first", 32'(busy_m), 1);
        chk("t1_mosi_first", 32'(mosi_m), 1);
        chk("t1_sclk_first", 32'(sclk_m), 0);
        wait_done(100);
        chk("t1_mosi_bits", 32'(got_mosi[7:0]), 32'hA5);
        chk("t1_rx", 32'(rx_at_done), 32'h3C);
        chk("t1_busy_len", n_busy, 36);
        chk("t1_cs_seen", 32'(cs_seen), 32'h1);
        chk("t1_rises", n_rise, 8);
        chk("t1_sclk_period", rise_per, 4);
        @(negedge clk);
        chk("t1_done_1cyc", 32'(done_m), 0);

        xfer(16'h00FF, 2'd1, 16'h0000);
        wait_done(100);
        chk("t2_cs_seen", 32'(cs_seen), 32'h2);
        chk("t2_rx", 32'(rx_at_done), 32'h00);
        chk("t2_mosi_bits", 32'(got_mosi[7:0]), 32'hFF);

        xfer(16'h005A, 2'd0, 16'h00C3);
        wait_done(100);
        chk("b2b_rx1", 32'(rx_at_done), 32'hC3);
        chk("b2b_gap_high", 32'(cs_n_m), 32'h3);
        start_v = 1'b1; tx_v = 16'h000F; pat = 16'h0096; clr = 1'b1;
        @(negedge clk);
        start_v = 1'b0; clr = 1'b0;
        chk("b2b_cs_low", 32'(cs_n_m), 32'h2);
        wait_done(100);
        chk("b2b_rx2", 32'(rx_at_done), 32'h96);
        chk("b2b_mosi2", 32'(got_mosi[7:0]), 32'h0F);

        repeat (3) @(negedge clk);
        xfer(16'h0055, 2'd2, 16'h0000);
        repeat (50) @(negedge clk);
        chk("ill_cs_seen", 32'(cs_seen), 0);
        chk("ill_sclk_edges", n_rise + n_fall, 0);
        chk("ill_done", n_done, 0);
        chk("ill_busy", n_busy, 0);

        xfer(16'h00C3, 2'd0, 16'h0081);
        repeat (10) @(negedge clk);
        start_v = 1'b1; tx_v = 16'h00FF; cs_v = 2'd1;
        @(negedge clk);
        start_v = 1'b0;
        wait_done(100);
        chk("mid_mosi", 32'(got_mosi[7:0]), 32'hC3);
        chk("mid_rx", 32'(rx_at_done), 32'h81);
        chk("mid_busy_len", n_busy, 36);
        repeat (40) @(negedge clk);
        chk("mid_single_done", n_done, 1);
        chk("mid_cs_seen", 32'(cs_seen), 32'h1);
        chk("no_edge_without_cs", n_bad, 0);

        xfer(16'h00A5, 2'd0, 16'h003C);
        for (int i = 0; i < 100 && n_rise < 3; i++) @(negedge clk);
        chk("rst_mid_rise3", n_rise, 3);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cs_n", 32'(cs_n_a), 32'h3);
        chk("rst_mid_sclk", 32'(sclk_a), 0);
        chk("rst_mid_busy", 32'(busy_a), 0);
        chk("rst_mid_rx", 32'(rx_a), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (60) @(negedge clk);
        chk("rst_mid_no_done", n_done, 0);
        chk("rst_mid_cs_idle", 32'(cs_seen), 0);

        sel = 1'b1;
        repeat (2) @(negedge clk);
        xfer(16'h1234, 2'd0, 16'h8001);
        wait_done(100);
        chk("w16_rx", 32'(rx_at_done), 32'h8001);
        chk("w16_busy_len", n_busy, 34);
        chk("w16_mosi_bits", 32'(got_mosi), 32'h1234);
        chk("w16_rises", n_rise, 16);
        chk("w16_sclk_period", rise_per, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_primary.md
Name: spi_primary

Overview:
SPI controller (primary) for the tag's sensor bus. It drives sclk, mosi and one active-low chip select per secondary, and samples the shared miso line. Host logic issues single-word transfers through a start/busy/done handshake. It sits directly upstream of the SPI secondary sensors and feeds them the serial bus they consume.

Parameters:
- DATA_W, default 8: bits per transfer, MSB first.
- CLK_DIV, default 2: clk cycles per sclk half-period; minimum 1.
- NUM_CS, default 2: number of chip-select lines / secondaries.
- CS_W, default $clog2(NUM_CS) (minimum 1): width of cs_sel.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request a transfer; sampled only in IDLE.
- tx_data, input, DATA_W: word to send; captured when start is accepted.
- cs_sel, input, CS_W: target secondary index; captured when start is accepted.
- busy, output, 1: high from the cycle after acceptance until done.
- done, output, 1: one-cycle pulse when rx_data is valid.
- rx_data, output, DATA_W: last received word; holds until the next done.
- sclk, output, 1: serial clock, idles low (CPOL=0).
- mosi, output, 1: serial data out.
- miso, input, 1: shared serial data in.
- cs_n, output, NUM_CS: active-low selects, at most one low at a time.

Behaviour:
- Mode 0 (CPOL=0, CPHA=0):
  - mosi changes only while sclk is low.
  - miso is sampled on the clk edge that drives sclk 0->1.
- Reset (asynchronous, immediate):
  - cs_n = all 1; sclk = 0; mosi = 0; busy = 0; done = 0; rx_data = 0.
  - State = IDLE; all counters = 0.
  - Reset mid-frame aborts the frame: no done pulse and rx_data cleared.
- States: IDLE, SETUP, SHIFT, HOLD.
- IDLE:
  - start=1 with cs_sel < NUM_CS -> SETUP.
  - start with cs_sel >= NUM_CS is ignored: no bus activity, no done.
- Timeline, with t0 = acceptance edge:
  - t0+1: cs_n[cs_sel] = 0, busy = 1, mosi = tx_data[DATA_W-1], sclk = 0. SETUP lasts CLK_DIV cycles.
  - SHIFT: sclk toggles every CLK_DIV cycles; the first rise is at t0+1+CLK_DIV.
  - Each rise: shift miso into the receive register LSB.
  - Each fall except the last: mosi takes the next lower bit.
  - After DATA_W rises and DATA_W falls (sclk back at 0) -> HOLD.
  - HOLD lasts CLK_DIV cycles with cs still asserted; then -> IDLE.
  - On entering IDLE: cs_n = all 1, busy = 0, done = 1 for one cycle, rx_data = received word, mosi = 0.
- busy duration: exactly CLK_DIV*(2*DATA_W+2) cycles.
- start while busy: ignored; no queuing.
- start in the done cycle: accepted (back-to-back). cs_n is high for exactly one cycle between frames.
- tx_data and cs_sel changes after acceptance: no effect on the current frame.
- Counters:
  - Divider counter: $clog2(CLK_DIV+1) bits, wraps at CLK_DIV-1.
  - Bit counter: $clog2(DATA_W+1) bits.
- Invariants:
  - No sclk edge occurs while all of cs_n are high.
  - All outputs are registered; no glitches.

Decomposition:
- spi_pkg holds the state encoding constants (IDLE/SETUP/SHIFT/HOLD) and the mode constants CPOL=0 and CPHA=0.
- One natural sub-module, spi_clk_div: a CLK_DIV tick generator with enable and synchronous clear. It emits a one-cycle tick each half-period; the FSM toggles sclk on each tick.

Test Plan:
- Basic transfer (DATA_W=8, CLK_DIV=2, secondary model returns 0x3C), tx_data=0xA5, cs_sel=0:
  - mosi at the rises = 1,0,1,0,0,1,0,1.
  - rx_data = 0x3C at done.
  - busy high for 36 cycles; cs_n = 2'b10 during the frame.
- Select second device, cs_sel=1, tx_data=0xFF, miso held 0:
  - cs_n = 2'b01, cs_n[0] never low.
  - rx_data = 0x00.
- Back-to-back: start asserted in the done cycle with tx_data=0x0F:
  - Second frame begins; cs_n high for exactly 1 cycle between frames.
  - Two done pulses.
- Illegal and busy starts:
  - cs_sel=2 with NUM_CS=2 -> no cs_n low, no sclk edge, no done over 50 cycles.
  - start pulsed mid-frame -> frame unaffected, single done.
- Reset mid-frame: rst_n low after the 3rd sclk rise:
  - Same cycle: cs_n = all 1, sclk = 0, busy = 0, rx_data = 0.
  - No done after release.
- CLK_DIV=1, DATA_W=16, miso pattern 0x8001:
  - sclk period of 2 clk cycles.
  - rx_data = 0x8001; busy high for 34 cycles.
